// File: rtl/dac_stream_driver_if.sv
// Sample stream into the DAC driver: offset-binary data with valid/ready handshake.
// Ready is purely a function of FIFO fullness, so it never depends on valid.
interface dac_stream_driver_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_stream_driver.sv
// Buffers stream samples and plays them to a parallel DAC at (D+1)-clock periods, D=max(rate_div,1).
// Latency: first sample on da_data two cycles after enable with a primed FIFO; s_ready drops only when full.
module dac_stream_driver #(
    parameter int  DATA_W      = 10,
    parameter int  FIFO_DEPTH  = 16,
    parameter int  PRIME_LEVEL = 8,
    parameter int  DIV_W       = 8,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    dac_stream_driver_if.slave s_if,
    input  logic               enable,
    input  logic               flush,
    input  logic [DIV_W-1:0]   rate_div,
    input  logic               clr_underflow,
    output logic [DATA_W-1:0]  da_data,
    output logic               da_clk,
    output logic               underflow,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               playing
);
    localparam int                AW        = $clog2(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  PRIME_LVL = LVL_W'(PRIME_LEVEL);

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [DIV_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0]  r_d, w_d_nxt, w_rate_d;
    logic [DIV_W:0]    w_half, w_cnt_inc;
    logic [DATA_W-1:0] r_da_data, w_da_data_nxt, w_head;
    logic              r_da_clk, w_da_clk_nxt;
    logic              r_underflow, w_uf_set;
    logic              w_full, w_push, w_pop;

    assign w_full       = (r_level == FULL_LVL);
    assign s_if.s_ready = ~w_full;
    assign w_push       = s_if.s_valid & ~w_full & ~flush;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_rate_d     = (rate_div == '0) ? DIV_W'(1) : rate_div;
    assign w_half       = ({1'b0, r_d} + (DIV_W+1)'(1)) >> 1;
    assign w_cnt_inc    = {1'b0, r_cnt} + (DIV_W+1)'(1);

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_if.s_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_d         <= DIV_W'(1);
            r_da_data   <= MIDSCALE;
            r_da_clk    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_d         <= w_d_nxt;
            r_da_data   <= w_da_data_nxt;
            r_da_clk    <= w_da_clk_nxt;
            r_underflow <= w_uf_set | (r_underflow & ~clr_underflow);
        end
    end

    // da_clk is computed for the cnt value being loaded, so it stays aligned with r_cnt.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_d_nxt       = r_d;
        w_da_data_nxt = r_da_data;
        w_da_clk_nxt  = 1'b0;
        w_pop         = 1'b0;
        w_uf_set      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_da_data_nxt = MIDSCALE;
                if (enable) begin
                    w_state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_da_data_nxt = MIDSCALE;
                end else if (!flush && r_level >= PRIME_LVL) begin
                    w_pop         = 1'b1;
                    w_state_nxt   = ST_RUN;
                    w_da_data_nxt = w_head;
                    w_d_nxt       = w_rate_d;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_da_data_nxt = MIDSCALE;
                end else if (flush) begin
                    w_state_nxt = ST_PRIME;
                end else if (r_cnt == r_d) begin
                    if (r_level != '0) begin
                        w_pop         = 1'b1;
                        w_da_data_nxt = w_head;
                        w_d_nxt       = w_rate_d;
                    end else begin
                        w_uf_set    = 1'b1;
                        w_state_nxt = ST_PRIME;
                    end
                end else begin
                    w_cnt_nxt    = w_cnt_inc[DIV_W-1:0];
                    w_da_clk_nxt = (w_cnt_inc >= w_half);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign da_data    = r_da_data;
    assign da_clk     = r_da_clk;
    assign underflow  = r_underflow;
    assign fifo_level = r_level;
    assign playing    = (r_state == ST_RUN);
endmodule

// File: tb/tb_dac_stream_driver.sv
// Directed bench for dac_stream_driver with a queue-based playback model checked every cycle.
`timescale 1ns/1ps
module tb_dac_stream_driver;
    localparam logic [9:0] MID = 10'h200;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       enable = 1'b0;
    logic       flush = 1'b0;
    logic       clr_underflow = 1'b0;
    logic [7:0] rate_div = 8'd3;
    logic [9:0] da_data;
    logic       da_clk, underflow, playing;
    logic [4:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    dac_stream_driver_if #(.DATA_W(10)) s_if ();

    dac_stream_driver dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .s_if          (s_if),
        .enable        (enable),
        .flush         (flush),
        .rate_div      (rate_div),
        .clr_underflow (clr_underflow),
        .da_data       (da_data),
        .da_clk        (da_clk),
        .underflow     (underflow),
        .fifo_level    (fifo_level),
        .playing       (playing)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of samples, mode (0 idle, 1 prime, 2 run), phase within a period of m_per clocks.
    logic [9:0] mq[$];
    int         m_mode = 0;
    int         m_ph = 0;
    int         m_per = 2;
    logic [9:0] m_dat = MID;
    bit         m_uf = 1'b0;
    bit         model_ok = 1'b0;
    bit         mp_pop, mp_push, mp_set;

    function automatic int period(input logic [7:0] r);
        return ((r == 8'd0) ? 1 : int'(r)) + 1;
    endfunction

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            mq.delete();
            m_mode   = 0;
            m_dat    = MID;
            m_ph     = 0;
            m_per    = 2;
            m_uf     = 1'b0;
            model_ok = 1'b1;
        end else begin
            mp_pop  = 1'b0;
            mp_set  = 1'b0;
            mp_push = s_if.s_valid && (mq.size() < 16) && !flush;
            case (m_mode)
                0: begin
                    m_dat = MID;
                    if (enable) m_mode = 1;
                end
                1: begin
                    if (!enable) begin
                        m_mode = 0;
                        m_dat  = MID;
                    end else if (!flush && mq.size() >= 8) begin
                        mp_pop = 1'b1;
                        m_dat  = mq[0];
                        m_per  = period(rate_div);
                        m_ph   = 0;
                        m_mode = 2;
                    end
                end
                default: begin
                    if (!enable) begin
                        m_mode = 0;
                        m_dat  = MID;
                    end else if (flush) begin
                        m_mode = 1;
                    end else if (m_ph == m_per - 1) begin
                        if (mq.size() > 0) begin
                            mp_pop = 1'b1;
                            m_dat  = mq[0];
                            m_per  = period(rate_div);
                            m_ph   = 0;
                        end else begin
                            mp_set = 1'b1;
                            m_mode = 1;
                        end
                    end else begin
                        m_ph++;
                    end
                end
            endcase
            if (mp_set) m_uf = 1'b1;
            else if (clr_underflow) m_uf = 1'b0;
            if (flush) begin
                mq.delete();
            end else begin
                if (mp_pop) void'(mq.pop_front());
                if (mp_push) mq.push_back(s_if.s_data);
            end
        end
    end

    always @(negedge sys_clk) begin
        if (model_ok) begin
            chk("m_da_data", da_data, m_dat);
            chk("m_da_clk", da_clk, (m_mode == 2) && (m_ph >= m_per / 2));
            chk("m_underflow", underflow, m_uf);
            chk("m_playing", playing, m_mode == 2);
            chk("m_fifo_level", fifo_level, mq.size());
            chk("m_s_ready", s_if.s_ready, mq.size() < 16);
        end
    end

    task automatic wait_play(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (playing) break;
            @(negedge sys_clk);
        end
        chk("play_start", playing, 1'b1);
    endtask

    // Return to IDLE, empty the FIFO, load 8 samples base.., then enable and wait for RUN.
    task automatic start_session(input logic [9:0] base, input logic [7:0] rd);
        enable = 1'b0;
        @(negedge sys_clk);
        flush = 1'b1;
        @(negedge sys_clk);
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = base + 10'(i);
            @(negedge sys_clk);
        end
        s_if.s_valid = 1'b0;
        rate_div = rd;
        enable = 1'b1;
        wait_play(10);
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        repeat (2) @(negedge sys_clk);
        chk("rst_da_data", da_data, 10'h200);
        chk("rst_da_clk", da_clk, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_playing", playing, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_s_ready", s_if.s_ready, 1'b1);
        sys_rst = 1'b0;

        // T1: samples 1..8 at rate 3, then underflow holding the last sample
        start_session(10'h001, 8'd3);
        for (int k = 0; k < 32; k++) begin
            chk("t1_data", da_data, 1 + k / 4);
            chk("t1_clk", da_clk, (k % 4) >= 2);
            @(negedge sys_clk);
        end
        chk("t1_underflow", underflow, 1'b1);
        chk("t1_prime", playing, 1'b0);
        chk("t1_hold", da_data, 10'h008);

        // T2: fill to full with playback disabled, then push+pop at level 10
        enable = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 17; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = 10'h100 + 10'(i);
            @(negedge sys_clk);
        end
        s_if.s_valid = 1'b0;
        chk("t2_full_level", fifo_level, 16);
        chk("t2_full_ready", s_if.s_ready, 1'b0);
        rate_div = 8'd0;
        enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (fifo_level == 5'd10 && da_clk) break;
            @(negedge sys_clk);
        end
        chk("t2_reach_10", (fifo_level == 5'd10) && da_clk, 1'b1);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 10'h1AA;
        @(negedge sys_clk);
        s_if.s_valid = 1'b0;
        chk("t2_pushpop_level", fifo_level, 10);
        for (int k = 0; k < 4; k++) begin
            chk("t3_rate0_clk", da_clk, k % 2);
            @(negedge sys_clk);
        end

        // T3: rate 4 gives low 2, high 3
        start_session(10'h280, 8'd4);
        for (int k = 0; k < 6; k++) begin
            chk("t3_rate4_data", da_data, (k < 5) ? 32'h280 : 32'h281);
            chk("t3_rate4_clk", da_clk, (k < 5) && (k >= 2));
            @(negedge sys_clk);
        end

        // T4: rate change 3->7 mid-period only affects the next period
        start_session(10'h300, 8'd3);
        for (int k = 0; k < 12; k++) begin
            chk("t4_data", da_data, (k < 4) ? 32'h300 : 32'h301);
            chk("t4_clk", da_clk, (k < 4) ? (k >= 2) : (k - 4 >= 4));
            if (k == 1) rate_div = 8'd7;
            @(negedge sys_clk);
        end

        clr_underflow = 1'b1;
        @(negedge sys_clk);
        clr_underflow = 1'b0;
        chk("clr_alone", underflow, 1'b0);

        // T5: flush in RUN at level 5, then disable in RUN
        start_session(10'h040, 8'd3);
        for (int i = 0; i < 20; i++) begin
            if (fifo_level == 5'd5) break;
            @(negedge sys_clk);
        end
        chk("t5_reach_5", fifo_level, 5);
        flush = 1'b1;
        @(negedge sys_clk);
        flush = 1'b0;
        chk("t5_flush_level", fifo_level, 0);
        chk("t5_flush_prime", playing, 1'b0);
        chk("t5_flush_uf", underflow, 1'b0);
        chk("t5_flush_hold", da_data, 10'h042);
        chk("t5_flush_clk", da_clk, 1'b0);
        start_session(10'h050, 8'd3);
        enable = 1'b0;
        @(negedge sys_clk);
        chk("t5_dis_playing", playing, 1'b0);
        chk("t5_dis_data", da_data, 10'h200);
        chk("t5_dis_level", fifo_level, 7);

        // T6: underflow set and clear in the same cycle, then clear alone
        start_session(10'h060, 8'd3);
        repeat (31) @(negedge sys_clk);
        clr_underflow = 1'b1;
        @(negedge sys_clk);
        clr_underflow = 1'b0;
        chk("t6_set_wins", underflow, 1'b1);
        chk("t6_hold", da_data, 10'h067);
        clr_underflow = 1'b1;
        @(negedge sys_clk);
        clr_underflow = 1'b0;
        chk("t6_clr", underflow, 1'b0);

        // Reset in the middle of playback
        start_session(10'h070, 8'd3);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("mrst_da_data", da_data, 10'h200);
        chk("mrst_da_clk", da_clk, 1'b0);
        chk("mrst_playing", playing, 1'b0);
        chk("mrst_level", fifo_level, 0);
        chk("mrst_s_ready", s_if.s_ready, 1'b1);
        sys_rst = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
